// File: rtl/spec_rd_arbiter.sv
// Read arbiter for a double-use spectrum RAM: two requesters share one read port
// while a frame is READY, and the writer is released once outstanding reads drain.
module spec_rd_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_done,
    input  logic              frame_release,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              frame_ready,
    output logic              capture_start,
    output logic              overrun
);

    // In-flight stages ahead of the output register; the last one lines up with ram_rd_data.
    localparam int DEPTH = RD_LAT + 1;

    typedef enum logic [1:0] {LOCKED, READY, DRAIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             grant;
    logic             grant_id;
    logic             in_flight;
    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] id_p;

    assign in_flight   = |vld_p;
    assign frame_ready = (state == READY);

    always_comb begin
        state_nxt     = state;
        grant         = 1'b0;
        grant_id      = 1'b0;
        capture_start = 1'b0;
        case (state)
            LOCKED: begin
                if (frame_done) state_nxt = READY;
            end
            READY: begin
                // A release in the same cycle as a request shuts arbitration off first.
                if (frame_release) begin
                    state_nxt = DRAIN;
                end else if (req0 && req1) begin
                    grant    = 1'b1;
                    grant_id = ptr;
                end else if (req0 || req1) begin
                    grant    = 1'b1;
                    grant_id = req1;
                end
            end
            DRAIN: begin
                if (!in_flight) begin
                    state_nxt     = LOCKED;
                    capture_start = 1'b1;
                end
            end
            default: state_nxt = LOCKED;
        endcase
        gnt0 = grant && !grant_id;
        gnt1 = grant && grant_id;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= LOCKED;
            ptr     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) ptr <= ~grant_id;
            if (frame_done && state != LOCKED) overrun <= 1'b1;
        end
    end

    // Stage boundary: grant -> RAM address register, then the valid/ID shift pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_addr <= '0;
            vld_p    <= '0;
        end else begin
            if (grant) ram_addr <= grant_id ? addr1 : addr0;
            vld_p <= {vld_p[DEPTH-2:0], grant};
        end
    end

    always_ff @(posedge clk) begin
        id_p <= {id_p[DEPTH-2:0], grant_id};
    end

    // Stage boundary: RAM data -> registered return with its requester tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= vld_p[DEPTH-1] && !id_p[DEPTH-1];
            rvalid1 <= vld_p[DEPTH-1] && id_p[DEPTH-1];
            if (vld_p[DEPTH-1]) rdata <= ram_rd_data;
        end
    end

endmodule

// File: tb/tb_spec_rd_arbiter.sv
// Bench for spec_rd_arbiter: directed vector table plus randomized traffic against
// a queue-based reference model (RD_LAT=1), and a second instance with RD_LAT=2.
module tb_spec_rd_arbiter;

    localparam int LAT1 = 1;

    logic        clk;
    logic        rst_n;
    logic        frame_done;
    logic        frame_release;
    logic        req0;
    logic        req1;
    logic [11:0] addr0;
    logic [11:0] addr1;

    logic        gnt0, gnt1, rvalid0, rvalid1, frame_ready, capture_start, overrun;
    logic [11:0] ram_addr;
    logic [15:0] ram_rd_data, rdata;

    logic        gnt0_2, gnt1_2, rvalid0_2, rvalid1_2, frame_ready_2, capture_start_2, overrun_2;
    logic [11:0] ram_addr_2;
    logic [15:0] ram_rd_data_2, rdata_2;
    logic [15:0] d2a;

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] mem(input logic [11:0] a);
        if (a == 12'h010) return 16'h1234;
        return {a[7:0], ~a[7:0]};
    endfunction

    spec_rd_arbiter #(.ADDR_W(12), .DATA_W(16), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .frame_done(frame_done), .frame_release(frame_release),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
        .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1), .frame_ready(frame_ready),
        .capture_start(capture_start), .overrun(overrun)
    );

    spec_rd_arbiter #(.ADDR_W(12), .DATA_W(16), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_done(frame_done), .frame_release(frame_release),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0_2), .gnt1(gnt1_2), .ram_addr(ram_addr_2), .ram_rd_data(ram_rd_data_2),
        .rdata(rdata_2), .rvalid0(rvalid0_2), .rvalid1(rvalid1_2), .frame_ready(frame_ready_2),
        .capture_start(capture_start_2), .overrun(overrun_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: data appears RD_LAT cycles after the address register changes.
    always @(posedge clk) begin
        ram_rd_data <= mem(ram_addr);
        d2a         <= mem(ram_addr_2);
        ram_rd_data_2 <= d2a;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (RD_LAT=1 instance) ----------------
    localparam int M_LOCKED = 0, M_READY = 1, M_DRAIN = 2;
    typedef struct {
        int          due;
        bit          id;
        logic [11:0] addr;
    } rd_t;

    rd_t pend[$];
    int  mst  = M_LOCKED;
    bit  mptr = 1'b0;
    bit  mov  = 1'b0;
    int  mcyc = 0;

    always @(negedge clk) begin
        bit          eg0, eg1, ev0, ev1, busy, ecap;
        logic [15:0] erd;
        eg0 = 0; eg1 = 0; ev0 = 0; ev1 = 0; busy = 0; erd = '0;
        if (mst == M_READY && !frame_release) begin
            if (req0 && (!req1 || mptr == 1'b0)) eg0 = 1;
            else if (req1) eg1 = 1;
        end
        foreach (pend[k]) begin
            if (pend[k].due == mcyc) begin
                if (pend[k].id) ev1 = 1; else ev0 = 1;
                erd = mem(pend[k].addr);
            end
            if (pend[k].due > mcyc) busy = 1;
        end
        ecap = (mst == M_DRAIN) && !busy;

        chk("model_gnt0", {31'b0, gnt0}, {31'b0, eg0});
        chk("model_gnt1", {31'b0, gnt1}, {31'b0, eg1});
        chk("model_frame_ready", {31'b0, frame_ready}, {31'b0, mst == M_READY});
        chk("model_rvalid0", {31'b0, rvalid0}, {31'b0, ev0});
        chk("model_rvalid1", {31'b0, rvalid1}, {31'b0, ev1});
        if (ev0 || ev1) chk("model_rdata", {16'b0, rdata}, {16'b0, erd});
        chk("model_capture_start", {31'b0, capture_start}, {31'b0, ecap});
        chk("model_overrun", {31'b0, overrun}, {31'b0, mov});

        if (!rst_n) begin
            pend.delete();
            mst  = M_LOCKED;
            mptr = 1'b0;
            mov  = 1'b0;
        end else begin
            if (eg0 || eg1) begin
                pend.push_back('{mcyc + LAT1 + 2, eg1, eg1 ? addr1 : addr0});
                mptr = eg0;
            end
            if (frame_done && mst != M_LOCKED) mov = 1'b1;
            case (mst)
                M_LOCKED: if (frame_done) mst = M_READY;
                M_READY:  if (frame_release) mst = M_DRAIN;
                default:  if (!busy) mst = M_LOCKED;
            endcase
        end
        while (pend.size() > 0 && pend[0].due <= mcyc) void'(pend.pop_front());
        mcyc++;
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rst_n, fd, fr, r0, r1;
        logic [11:0] a0, a1;
        bit          g0, g1, rdy, v0, v1;
        logic [15:0] rd;
        bit          cap, ovr, chk2, v0b;
    } vec_t;

    vec_t tbl[$];
    bit   g0s, g1s;

    initial begin
        //               rst fd fr r0 r1 a0      a1       g0 g1 rdy v0 v1 rd        cap ovr c2 v0b
        tbl.push_back('{0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0}); // 0 reset
        tbl.push_back('{1, 0, 0, 1, 0, 12'h010, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0}); // 1 req in LOCKED
        tbl.push_back('{1, 1, 0, 1, 0, 12'h010, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0}); // 2 frame_done
        tbl.push_back('{1, 0, 0, 1, 0, 12'h010, 12'h000, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0}); // 3 first grant
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 12'h000, 12'h020, 0, 1, 1, 1, 0, 16'h1234, 0, 0, 0, 0}); // 6 rvalid0, lone req1
        tbl.push_back('{1, 0, 0, 1, 1, 12'h030, 12'h040, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0}); // 7 both: alternate
        tbl.push_back('{1, 0, 0, 1, 1, 12'h030, 12'h040, 0, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 12'h030, 12'h040, 1, 0, 1, 0, 1, 16'h20DF, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 12'h030, 12'h040, 0, 1, 1, 1, 0, 16'h30CF, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 12'h030, 12'h040, 1, 0, 1, 0, 1, 16'h40BF, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 12'h030, 12'h040, 0, 1, 1, 1, 0, 16'h30CF, 0, 0, 0, 0}); // 12
        tbl.push_back('{1, 0, 1, 1, 0, 12'h030, 12'h000, 0, 0, 1, 0, 1, 16'h40BF, 0, 0, 0, 0}); // 13 release beats req
        tbl.push_back('{1, 0, 0, 1, 0, 12'h030, 12'h000, 0, 0, 0, 1, 0, 16'h30CF, 0, 0, 0, 0}); // 14 DRAIN
        tbl.push_back('{1, 0, 0, 1, 0, 12'h030, 12'h000, 0, 0, 0, 0, 1, 16'h40BF, 1, 0, 0, 0}); // 15 capture
        tbl.push_back('{1, 1, 1, 1, 0, 12'h030, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0}); // 16 done+release
        tbl.push_back('{1, 1, 0, 1, 0, 12'h030, 12'h000, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0}); // 17 done in READY
        tbl.push_back('{1, 0, 1, 0, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 0}); // 18 overrun, release
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 1, 0, 16'h30CF, 1, 1, 0, 0}); // 20
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0}); // 22 reset applied
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0}); // 23 overrun cleared
        tbl.push_back('{1, 1, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 12'h010, 12'h000, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0}); // 25 grant
        tbl.push_back('{0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0}); // 26 reset mid-read
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0}); // 27
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0}); // 30 both instances
        tbl.push_back('{1, 0, 0, 1, 0, 12'h010, 12'h000, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 1, 1, 0, 16'h1234, 0, 0, 1, 0}); // 34 RD_LAT=1 return
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 1}); // 35 RD_LAT=2 return
        tbl.push_back('{1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0});

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; frame_done = tbl[i].fd; frame_release = tbl[i].fr;
            req0 = tbl[i].r0; req1 = tbl[i].r1; addr0 = tbl[i].a0; addr1 = tbl[i].a1;
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i), {31'b0, gnt0}, {31'b0, tbl[i].g0});
            chk($sformatf("v%0d_gnt1", i), {31'b0, gnt1}, {31'b0, tbl[i].g1});
            chk($sformatf("v%0d_frame_ready", i), {31'b0, frame_ready}, {31'b0, tbl[i].rdy});
            chk($sformatf("v%0d_rvalid0", i), {31'b0, rvalid0}, {31'b0, tbl[i].v0});
            chk($sformatf("v%0d_rvalid1", i), {31'b0, rvalid1}, {31'b0, tbl[i].v1});
            if (tbl[i].v0 || tbl[i].v1)
                chk($sformatf("v%0d_rdata", i), {16'b0, rdata}, {16'b0, tbl[i].rd});
            chk($sformatf("v%0d_capture_start", i), {31'b0, capture_start}, {31'b0, tbl[i].cap});
            chk($sformatf("v%0d_overrun", i), {31'b0, overrun}, {31'b0, tbl[i].ovr});
            if (i == 0 || i == 27) begin
                chk($sformatf("v%0d_reset_ram_addr", i), {20'b0, ram_addr}, 32'h0);
                chk($sformatf("v%0d_reset_rdata", i), {16'b0, rdata}, 32'h0);
            end
            if (tbl[i].chk2) begin
                chk($sformatf("v%0d_lat2_gnt0", i), {31'b0, gnt0_2}, {31'b0, tbl[i].g0});
                chk($sformatf("v%0d_lat2_gnt1", i), {31'b0, gnt1_2}, {31'b0, tbl[i].g1});
                chk($sformatf("v%0d_lat2_frame_ready", i), {31'b0, frame_ready_2}, {31'b0, tbl[i].rdy});
                chk($sformatf("v%0d_lat2_rvalid0", i), {31'b0, rvalid0_2}, {31'b0, tbl[i].v0b});
                chk($sformatf("v%0d_lat2_rvalid1", i), {31'b0, rvalid1_2}, 32'h0);
                chk($sformatf("v%0d_lat2_capture_start", i), {31'b0, capture_start_2}, 32'h0);
                chk($sformatf("v%0d_lat2_overrun", i), {31'b0, overrun_2}, 32'h0);
                if (tbl[i].v0b) chk($sformatf("v%0d_lat2_rdata", i), {16'b0, rdata_2}, 32'h1234);
            end
            @(posedge clk);
            #1;
        end

        // Randomized traffic: requesters hold req and addr until granted.
        g0s = 0; g1s = 0;
        for (int n = 0; n < 3000; n++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            frame_done    = ($urandom_range(0, 15) == 0);
            frame_release = ($urandom_range(0, 9) == 0);
            if (!req0 || g0s) begin
                req0  = ($urandom_range(0, 2) != 0);
                addr0 = 12'($urandom);
            end
            if (!req1 || g1s) begin
                req1  = ($urandom_range(0, 2) != 0);
                addr1 = 12'($urandom);
            end
            @(negedge clk);
            g0s = gnt0;
            g1s = gnt1;
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
